setup_placer: RTL

SETUP_PLACER -- requirements
Module: setup_placer

---
 rtl/setup_placer_pkg.sv | 40 ++++
 rtl/setup_placer_lfsr16.sv | 24 ++
 rtl/setup_placer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/setup_placer_pkg.sv
// Shared geometry, LFSR constants, FSM state type and small helpers for the
// setup placer (nest + food placement on a 160x120 playfield).
package setup_placer_pkg;

    localparam int X_bits      = 8;
    localparam int Y_bits      = 8;
    localparam int SCREEN_W    = 160;
    localparam int SCREEN_H    = 120;
    localparam int NEST_RADIUS = 8;
    localparam int FOOD_RADIUS = 4;

    localparam logic [15:0] LFSR_MASK         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE, GEN_N, CHK_N, SET_N, GEN_F, CHK_F, SET_F, FIN
    } state_t;

    // One Galois step, x^16+x^14+x^13+x^11+1, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Candidate keeps a margin of r from every screen edge. Operands are
    // widened by one bit so the subtraction and compares never wrap.
    function automatic logic in_bounds(input logic [X_bits-1:0] x,
                                       input logic [Y_bits-1:0] y,
                                       input int r);
        logic [X_bits:0] xe, xlo, xhi;
        logic [Y_bits:0] ye, ylo, yhi;
        xe  = {1'b0, x};
        xlo = (X_bits+1)'(r);
        xhi = (X_bits+1)'(SCREEN_W - 1 - r);
        ye  = {1'b0, y};
        ylo = (Y_bits+1)'(r);
        yhi = (Y_bits+1)'(SCREEN_H - 1 - r);
        return (xe >= xlo) && (xe <= xhi) && (ye >= ylo) && (ye <= yhi);
    endfunction

endpackage

// File: rtl/setup_placer_lfsr16.sv
// 16-bit Galois LFSR. Ld has priority over En; a zero seed is replaced by
// the nonzero default so the register can never lock up at all-zeros.
module lfsr16
    import setup_placer_pkg::*;
(
    input  logic        Clk,
    input  logic        RESET,
    input  logic        Ld,
    input  logic [15:0] seed,
    input  logic        En,
    output logic [15:0] q
);

    // Load, step or hold the shift register.
    always_ff @(posedge Clk) begin
        if (RESET)
            q <= LFSR_SEED_DEFAULT;
        else if (Ld)
            q <= (seed == 16'h0000) ? LFSR_SEED_DEFAULT : seed;
        else if (En)
            q <= lfsr_step(q);
    end

endmodule

// File: rtl/setup_placer.sv
// Setup placer: picks a random nest position, then NUM_FOOD food positions,
// rejecting candidates that violate edge margins or collide. Each attempt is
// GEN (step LFSR, register candidate) + CHK (judge it); an accepted candidate
// spends one more cycle in SET strobing the load.
// Optional feature macro: PLACER_RETRY_LIMIT_EN -- bounds food retries to
// MAX_RETRY per item and counts abandoned items in 'skipped'.
module setup_placer
    import setup_placer_pkg::*;
#(
    parameter int NUM_FOOD  = 4,
    parameter int MAX_RETRY = 15
)(
    input  logic              Clk,
    input  logic              RESET,
    input  logic              START,
    input  logic [15:0]       seed,
    input  logic              nest_collision,
    input  logic              food_collision,
    output logic              SETUP_PHASE,
    output logic              SET_NEST,
    output logic              SET_FOOD,
    output logic [3:0]        food_idx,
    output logic [X_bits-1:0] cand_x,
    output logic [Y_bits-1:0] cand_y,
    output logic              DONE,
    output logic [3:0]        skipped
);

    if (NUM_FOOD < 1 || NUM_FOOD > 15) begin : g_bad_num_food
        $error("setup_placer: NUM_FOOD out of range 1..15");
    end
    if (MAX_RETRY < 1 || MAX_RETRY > 255) begin : g_bad_max_retry
        $error("setup_placer: MAX_RETRY out of range 1..255");
    end

    state_t      state;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nxt;
    logic        start_acc;
    logic        gen_cycle;
    logic        nest_ok;
    logic        food_ok;
    logic        last_food;
    logic        give_up;

    assign start_acc = START && (state == IDLE || state == FIN);
    assign gen_cycle = (state == GEN_N) || (state == GEN_F);
    assign lfsr_nxt  = lfsr_step(lfsr_q);
    assign nest_ok   = in_bounds(cand_x, cand_y, NEST_RADIUS);
    assign food_ok   = in_bounds(cand_x, cand_y, FOOD_RADIUS) &&
                       !nest_collision && !food_collision;
    assign last_food = (food_idx == 4'(NUM_FOOD - 1));
    assign SET_NEST  = (state == SET_N);
    assign SET_FOOD  = (state == SET_F);

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .RESET (RESET),
        .Ld    (start_acc),
        .seed  (seed),
        .En    (gen_cycle),
        .q     (lfsr_q)
    );

`ifdef PLACER_RETRY_LIMIT_EN
    logic [7:0] retry;
    logic [3:0] skip_cnt;

    assign give_up = (state == CHK_F) && !food_ok &&
                     (retry == 8'(MAX_RETRY - 1));
    assign skipped = skip_cnt;

    // Per-item rejection counter and running count of abandoned items.
    always_ff @(posedge Clk) begin
        if (RESET || start_acc) begin
            retry    <= '0;
            skip_cnt <= '0;
        end else if (state == SET_N) begin
            retry <= '0;
        end else if (state == CHK_F) begin
            if (food_ok) begin
                retry <= '0;
            end else if (give_up) begin
                retry    <= '0;
                skip_cnt <= skip_cnt + 4'd1;
            end else begin
                retry <= retry + 8'd1;
            end
        end
    end
`else
    assign give_up = 1'b0;
    assign skipped = '0;
`endif

    // Placement FSM with registered candidate and status outputs.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            state       <= IDLE;
            cand_x      <= '0;
            cand_y      <= '0;
            food_idx    <= '0;
            SETUP_PHASE <= 1'b0;
            DONE        <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (START) begin
                        state       <= GEN_N;
                        food_idx    <= '0;
                        DONE        <= 1'b0;
                        SETUP_PHASE <= 1'b1;
                    end
                end
                GEN_N: begin
                    cand_x <= lfsr_nxt[X_bits-1:0];
                    cand_y <= lfsr_nxt[15 -: Y_bits];
                    state  <= CHK_N;
                end
                CHK_N: state <= nest_ok ? SET_N : GEN_N;
                SET_N: state <= GEN_F;
                GEN_F: begin
                    cand_x <= lfsr_nxt[X_bits-1:0];
                    cand_y <= lfsr_nxt[15 -: Y_bits];
                    state  <= CHK_F;
                end
                CHK_F: begin
                    if (food_ok) begin
                        state <= SET_F;
                    end else if (give_up) begin
                        // Abandon this item, advancing exactly like SET_F.
                        food_idx <= food_idx + 4'd1;
                        if (last_food) begin
                            state       <= FIN;
                            DONE        <= 1'b1;
                            SETUP_PHASE <= 1'b0;
                        end else begin
                            state <= GEN_F;
                        end
                    end else begin
                        state <= GEN_F;
                    end
                end
                SET_F: begin
                    food_idx <= food_idx + 4'd1;
                    if (last_food) begin
                        state       <= FIN;
                        DONE        <= 1'b1;
                        SETUP_PHASE <= 1'b0;
                    end else begin
                        state <= GEN_F;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
